// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: state codes, lamp
// encodings and the lamp decode helpers used by the top-level scheduler.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 3;

  // Lamp vector, index 0 is the red lamp: 100 red, 010 green, 001 yellow.
  typedef logic [0:LIGHT_W-1] light_t;

  localparam light_t LIGHT_RED    = 3'b100;
  localparam light_t LIGHT_GREEN  = 3'b010;
  localparam light_t LIGHT_YELLOW = 3'b001;

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
    StAllRedA    = 3'd2,
    StSideGreen  = 3'd3,
    StSideYellow = 3'd4,
    StAllRedB    = 3'd5,
    StPedWalk    = 3'd6
  } state_t;

  function automatic light_t main_lamp(state_t s);
    case (s)
      StMainGreen:  main_lamp = LIGHT_GREEN;
      StMainYellow: main_lamp = LIGHT_YELLOW;
      default:      main_lamp = LIGHT_RED;
    endcase
  endfunction

  function automatic light_t side_lamp(state_t s);
    case (s)
      StSideGreen:  side_lamp = LIGHT_GREEN;
      StSideYellow: side_lamp = LIGHT_YELLOW;
      default:      side_lamp = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// Request/lamp bundle between the intersection scheduler and its environment.
//   tick, side_req, ped_req       : timebase enable and demand inputs
//   main_light, side_light, walk  : lamp outputs
//   ped_pending, phase            : status/debug outputs
// master: environment side (drives inputs). slave: scheduler side.
interface intersection_scheduler_if;
  import traffic_pkg::*;

  logic       tick;
  logic       side_req;
  logic       ped_req;
  light_t     main_light;
  light_t     side_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output tick, side_req, ped_req,
    input  main_light, side_light, walk, ped_pending, phase
  );

  modport slave (
    input  tick, side_req, ped_req,
    output main_light, side_light, walk, ped_pending, phase
  );

endinterface

// File: rtl/phase_timer.sv
// Saturating tick counter for the current phase.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : synchronous clear (takes priority over enable)
//   enable         : count one tick
//   count          : ticks spent in the current phase, sticks at all-ones
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection plus pedestrian crossing controller.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus (slave)    : tick/side_req/ped_req in; registered lamps, walk,
//                    ped_pending and phase out
// Lamps are registered from the next state so they change on the same edge
// as phase.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_MAIN_MIN = 10,
  parameter int unsigned T_SIDE_MAX = 6,
  parameter int unsigned T_YELLOW   = 3,
  parameter int unsigned T_ALL_RED  = 1,
  parameter int unsigned T_WALK     = 5
) (
  input logic                     clock,
  input logic                     reset_n,
  intersection_scheduler_if.slave bus
);

  // Timer value on the last tick of each phase.
  localparam logic [CNT_W-1:0] MainLast  = CNT_W'(T_MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] SideLast  = CNT_W'(T_SIDE_MAX - 1);
  localparam logic [CNT_W-1:0] YelLast   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] ClearLast = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] WalkLast  = CNT_W'(T_WALK - 1);

  state_t           state_q, state_d;
  logic             ped_q, ped_d;
  logic [CNT_W-1:0] timer;
  logic             timer_clear;

  assign timer_clear = (state_d != state_q);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (bus.tick),
    .count  (timer)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StMainGreen: begin
        if (bus.tick && (timer >= MainLast) && (bus.side_req || ped_q)) state_d = StMainYellow;
      end
      StMainYellow: begin
        if (bus.tick && (timer == YelLast)) state_d = StAllRedA;
      end
      StAllRedA: begin
        if (bus.tick && (timer == ClearLast)) begin
          if (ped_q)             state_d = StPedWalk;
          else if (bus.side_req) state_d = StSideGreen;
          else                   state_d = StMainGreen;
        end
      end
      StSideGreen: begin
        if (bus.tick && ((timer == SideLast) || !bus.side_req)) state_d = StSideYellow;
      end
      StSideYellow: begin
        if (bus.tick && (timer == YelLast)) state_d = StAllRedB;
      end
      StAllRedB: begin
        if (bus.tick && (timer == ClearLast)) state_d = ped_q ? StPedWalk : StMainGreen;
      end
      StPedWalk: begin
        if (bus.tick && (timer == WalkLast)) state_d = StMainGreen;
      end
      // Unreachable code 7 recovers to all-red without waiting for a tick.
      default: state_d = StAllRedB;
    endcase
  end

  // A new press on the walk-entry edge wins over the clear.
  always_comb begin
    ped_d = bus.ped_req |
            (ped_q & ~((state_d == StPedWalk) && (state_q != StPedWalk)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StAllRedB;
      ped_q          <= 1'b0;
      bus.main_light <= LIGHT_RED;
      bus.side_light <= LIGHT_RED;
      bus.walk       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ped_q          <= ped_d;
      bus.main_light <= main_lamp(state_d);
      bus.side_light <= side_lamp(state_d);
      bus.walk       <= (state_d == StPedWalk);
    end
  end

  assign bus.ped_pending = ped_q;
  assign bus.phase       = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
module tb_intersection_scheduler;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  intersection_scheduler_if bus ();

  intersection_scheduler #(
    .CNT_W     (8),
    .T_MAIN_MIN(4),
    .T_SIDE_MAX(6),
    .T_YELLOW  (2),
    .T_ALL_RED (1),
    .T_WALK    (3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-written lamp table: red=4, green=2, yellow=1.
  function automatic logic [7:0] exp_main(input int ph);
    case (ph)
      0:       exp_main = 8'd2;
      1:       exp_main = 8'd1;
      default: exp_main = 8'd4;
    endcase
  endfunction

  function automatic logic [7:0] exp_side(input int ph);
    case (ph)
      3:       exp_side = 8'd2;
      4:       exp_side = 8'd1;
      default: exp_side = 8'd4;
    endcase
  endfunction

  // Check n consecutive cycles in phase ph, sampling on the falling edge.
  task automatic expect_run(input string tag, input int ph, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_phase"}, {5'd0, bus.phase}, 8'(ph));
      chk({tag, "_main"}, {5'd0, bus.main_light}, exp_main(ph));
      chk({tag, "_side"}, {5'd0, bus.side_light}, exp_side(ph));
      chk({tag, "_walk"}, {7'd0, bus.walk}, (ph == 6) ? 8'd1 : 8'd0);
      @(negedge clock);
    end
  endtask

  // Safety monitor on every cycle.
  always @(negedge clock) begin
    total++;
    assert (!((bus.main_light !== 3'b100) && (bus.side_light !== 3'b100)) &&
            !(bus.walk && ((bus.main_light !== 3'b100) || (bus.side_light !== 3'b100))))
    else begin
      bad++;
      $error("FAIL safety observed main=%b side=%b walk=%b required both red when not exclusive",
             bus.main_light, bus.side_light, bus.walk);
    end
  end

  initial begin
    reset_n     = 1'b0;
    bus.tick    = 1'b1;
    bus.side_req = 1'b0;
    bus.ped_req = 1'b0;
    total       = 0;
    bad         = 0;
    repeat (2) @(negedge clock);

    // Reset state.
    chk("rst_phase", {5'd0, bus.phase}, 8'd5);
    chk("rst_main", {5'd0, bus.main_light}, 8'd4);
    chk("rst_side", {5'd0, bus.side_light}, 8'd4);
    chk("rst_walk", {7'd0, bus.walk}, 8'd0);
    chk("rst_ped", {7'd0, bus.ped_pending}, 8'd0);

    // Release: one all-red cycle then main green held with no demand.
    reset_n = 1'b1;
    expect_run("rel", 5, 1);
    expect_run("hold", 0, 8);

    // Restart with side demand present from main green entry.
    reset_n = 1'b0;
    #1;
    chk("rst2_phase", {5'd0, bus.phase}, 8'd5);
    chk("rst2_main", {5'd0, bus.main_light}, 8'd4);
    @(negedge clock);
    reset_n = 1'b1;
    bus.side_req = 1'b1;
    expect_run("sd_ar", 5, 1);
    expect_run("sd_mg", 0, 4);
    expect_run("sd_my", 1, 2);
    expect_run("sd_ara", 2, 1);
    expect_run("sd_sg", 3, 6);
    expect_run("sd_sy", 4, 2);
    expect_run("sd_arb", 5, 1);

    // Early side release: side green lasts 3 cycles.
    expect_run("er_mg", 0, 4);
    expect_run("er_my", 1, 2);
    expect_run("er_ara", 2, 1);
    expect_run("er_sg", 3, 2);
    bus.side_req = 1'b0;
    expect_run("er_sg3", 3, 1);
    expect_run("er_sy", 4, 2);
    expect_run("er_arb", 5, 1);

    // Pedestrian press at main-green timer=1.
    expect_run("pd_mg0", 0, 1);
    bus.ped_req = 1'b1;
    chk("pd_pre", {7'd0, bus.ped_pending}, 8'd0);
    @(negedge clock);
    bus.ped_req = 1'b0;
    chk("pd_latch", {7'd0, bus.ped_pending}, 8'd1);
    expect_run("pd_mg", 0, 2);
    expect_run("pd_my", 1, 2);
    expect_run("pd_ara", 2, 1);
    chk("pd_clr", {7'd0, bus.ped_pending}, 8'd0);
    expect_run("pd_walk", 6, 3);
    expect_run("pd_mg2", 0, 2);

    // Pedestrian and side both pending: walk first, then side.
    bus.ped_req = 1'b1;
    bus.side_req = 1'b1;
    expect_run("ps_mg0", 0, 1);
    bus.ped_req = 1'b0;
    expect_run("ps_mg", 0, 1);
    expect_run("ps_my", 1, 2);
    expect_run("ps_ara", 2, 1);
    expect_run("ps_walk", 6, 3);
    expect_run("ps_mg2", 0, 4);
    expect_run("ps_my2", 1, 2);
    expect_run("ps_ara2", 2, 1);
    expect_run("ps_sg", 3, 1);
    bus.ped_req = 1'b1;
    expect_run("ps_sg2", 3, 1);
    bus.ped_req = 1'b0;
    chk("ps_ped", {7'd0, bus.ped_pending}, 8'd1);

    // Reset mid side green: all red immediately, ped latch dropped.
    reset_n = 1'b0;
    #1;
    chk("mr_phase", {5'd0, bus.phase}, 8'd5);
    chk("mr_main", {5'd0, bus.main_light}, 8'd4);
    chk("mr_side", {5'd0, bus.side_light}, 8'd4);
    chk("mr_walk", {7'd0, bus.walk}, 8'd0);
    chk("mr_ped", {7'd0, bus.ped_pending}, 8'd0);
    @(negedge clock);

    // tick=0 freezes the controller for 20 cycles; a press still latches.
    reset_n = 1'b1;
    bus.tick = 1'b0;
    bus.side_req = 1'b0;
    expect_run("fz_a", 5, 10);
    bus.ped_req = 1'b1;
    expect_run("fz_b", 5, 1);
    bus.ped_req = 1'b0;
    chk("fz_ped", {7'd0, bus.ped_pending}, 8'd1);
    expect_run("fz_c", 5, 9);
    bus.tick = 1'b1;
    expect_run("fz_arb", 5, 1);
    chk("fz_clr", {7'd0, bus.ped_pending}, 8'd0);
    expect_run("fz_walk", 6, 3);
    expect_run("fz_mg", 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
